// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the phase-1 datapath.
// Sole bus master: drives the one-hot bus select plus all register load enables.
module datapath_sequencer #(
    parameter logic [4:0] OPC_ALU_MAX = 5'd12,
    parameter logic [4:0] OPC_MUL     = 5'd15,
    parameter logic [4:0] OPC_DIV     = 5'd16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [31:0] bus_select,
    output logic [15:0] reg_enable,
    output logic        y_enable,
    output logic        z_enable,
    output logic        hi_enable,
    output logic        lo_enable,
    output logic        pc_enable,
    output logic        ir_enable,
    output logic        mar_enable,
    output logic        mdr_enable,
    output logic        mdr_read,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    state_t state, state_next;

    logic [4:0] opc_q;
    logic [3:0] ra_q, rb_q, rc_q;

    logic [4:0] ir_opc;
    logic [3:0] ir_rb;
    logic       ir_legal;
    logic       ir_muldiv;
    logic       opc_muldiv;
    logic       unused_ir_bits;

    assign ir_opc         = ir[31:27];
    assign ir_rb          = ir[22:19];
    assign ir_muldiv      = (ir_opc == OPC_MUL) || (ir_opc == OPC_DIV);
    assign ir_legal       = (ir_opc <= OPC_ALU_MAX) || ir_muldiv;
    assign opc_muldiv     = (opc_q == OPC_MUL) || (opc_q == OPC_DIV);
    assign unused_ir_bits = ^ir[14:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IR only becomes valid in T3, so the fields are captured there for T4..T6.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            opc_q <= '0;
            ra_q  <= '0;
            rb_q  <= '0;
            rc_q  <= '0;
        end else if (state == T3) begin
            opc_q <= ir[31:27];
            ra_q  <= ir[26:23];
            rb_q  <= ir[22:19];
            rc_q  <= ir[18:15];
        end
    end

    always_comb begin
        state_next = state;
        bus_select = '0;
        reg_enable = '0;
        y_enable   = 1'b0;
        z_enable   = 1'b0;
        hi_enable  = 1'b0;
        lo_enable  = 1'b0;
        pc_enable  = 1'b0;
        ir_enable  = 1'b0;
        mar_enable = 1'b0;
        mdr_enable = 1'b0;
        mdr_read   = 1'b0;
        inc_pc     = 1'b0;
        alu_op     = '0;
        busy       = (state != IDLE);
        done       = 1'b0;
        illegal    = 1'b0;

        case (state)
            IDLE: begin
                if (run) state_next = T0;
            end
            T0: begin
                bus_select[20] = 1'b1;
                mar_enable     = 1'b1;
                inc_pc         = 1'b1;
                z_enable       = 1'b1;
                state_next     = T1;
            end
            // PC is reloaded from Z on every wait cycle; harmless because Z is unchanged.
            T1: begin
                bus_select[19] = 1'b1;
                pc_enable      = 1'b1;
                mdr_read       = 1'b1;
                mdr_enable     = mem_ready;
                if (mem_ready) state_next = T2;
            end
            T2: begin
                bus_select[21] = 1'b1;
                ir_enable      = 1'b1;
                state_next     = T3;
            end
            T3: begin
                if (!ir_legal) begin
                    illegal    = 1'b1;
                    state_next = run ? T0 : IDLE;
                end else if (ir_opc == 5'd0) begin
                    done       = 1'b1;
                    state_next = run ? T0 : IDLE;
                end else begin
                    bus_select = 32'd1 << ir_rb;
                    y_enable   = 1'b1;
                    state_next = T4;
                end
            end
            T4: begin
                bus_select = 32'd1 << rc_q;
                alu_op     = opc_q;
                z_enable   = 1'b1;
                state_next = T5;
            end
            T5: begin
                bus_select[19] = 1'b1;
                if (opc_muldiv) begin
                    lo_enable  = 1'b1;
                    state_next = T6;
                end else begin
                    reg_enable = 16'd1 << ra_q;
                    done       = 1'b1;
                    state_next = run ? T0 : IDLE;
                end
            end
            T6: begin
                bus_select[18] = 1'b1;
                hi_enable      = 1'b1;
                done           = 1'b1;
                state_next     = run ? T0 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed self-checking bench for datapath_sequencer: fetch wait states,
// ALU/MUL/illegal sequences, run drop and asynchronous reset mid-instruction.
module tb_datapath_sequencer;

    logic        clk;
    logic        clr;
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    logic [31:0] bus_select;
    logic [15:0] reg_enable;
    logic        y_enable, z_enable, hi_enable, lo_enable;
    logic        pc_enable, ir_enable, mar_enable, mdr_enable;
    logic        mdr_read, inc_pc, busy, done, illegal;
    logic [4:0]  alu_op;

    int checks = 0;
    int errors = 0;

    // Control flag layout, MSB first: y z hi lo pc ir mar mdr mdr_read inc_pc busy done illegal
    localparam logic [31:0] F_Y    = 32'h1000;
    localparam logic [31:0] F_Z    = 32'h0800;
    localparam logic [31:0] F_HI   = 32'h0400;
    localparam logic [31:0] F_LO   = 32'h0200;
    localparam logic [31:0] F_PC   = 32'h0100;
    localparam logic [31:0] F_IR   = 32'h0080;
    localparam logic [31:0] F_MAR  = 32'h0040;
    localparam logic [31:0] F_MDR  = 32'h0020;
    localparam logic [31:0] F_MRD  = 32'h0010;
    localparam logic [31:0] F_INC  = 32'h0008;
    localparam logic [31:0] F_BUSY = 32'h0004;
    localparam logic [31:0] F_DONE = 32'h0002;
    localparam logic [31:0] F_ILL  = 32'h0001;

    localparam logic [31:0] B_ZHI = 32'h0004_0000;
    localparam logic [31:0] B_ZLO = 32'h0008_0000;
    localparam logic [31:0] B_PC  = 32'h0010_0000;
    localparam logic [31:0] B_MDR = 32'h0020_0000;

    datapath_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .mem_ready  (mem_ready),
        .ir         (ir),
        .bus_select (bus_select),
        .reg_enable (reg_enable),
        .y_enable   (y_enable),
        .z_enable   (z_enable),
        .hi_enable  (hi_enable),
        .lo_enable  (lo_enable),
        .pc_enable  (pc_enable),
        .ir_enable  (ir_enable),
        .mar_enable (mar_enable),
        .mdr_enable (mdr_enable),
        .mdr_read   (mdr_read),
        .inc_pc     (inc_pc),
        .alu_op     (alu_op),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ir_val, input logic run_val, input logic ready_val);
        ir        = ir_val;
        run       = run_val;
        mem_ready = ready_val;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkState(input string tag, input logic [31:0] bus_exp, input logic [31:0] reg_exp,
                              input logic [31:0] ctl_exp, input logic [31:0] alu_exp);
        logic [31:0] ctl;
        ctl = {19'd0, y_enable, z_enable, hi_enable, lo_enable, pc_enable, ir_enable, mar_enable,
               mdr_enable, mdr_read, inc_pc, busy, done, illegal};
        checkOutput({tag, "_bus"}, bus_select, bus_exp);
        checkOutput({tag, "_reg"}, {16'd0, reg_enable}, reg_exp);
        checkOutput({tag, "_ctl"}, ctl, ctl_exp);
        checkOutput({tag, "_alu"}, {27'd0, alu_op}, alu_exp);
        checkOutput({tag, "_bus_onehot"}, {31'd0, $countones(bus_select) <= 1}, 32'd1);
        checkOutput({tag, "_reg_onehot"}, {31'd0, $countones(reg_enable) <= 1}, 32'd1);
    endtask

    initial begin
        clr = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b1);
        #1 clr = 1'b0;
        #2 checkState("reset", 0, 0, 0, 0);

        // ALU op 3, ra=2 rb=2 rc=0, back-to-back with the next instruction
        #9;
        applyStimulus(32'h1910_0000, 1'b1, 1'b1);
        clr = 1'b1;
        tick(); checkState("alu_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        tick(); checkState("alu_t1", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("alu_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        tick(); checkState("alu_t3", 32'h0000_0004, 0, F_Y | F_BUSY, 0);
        tick(); checkState("alu_t4", 32'h0000_0001, 0, F_Z | F_BUSY, 3);
        tick(); checkState("alu_t5", B_ZLO, 32'h0004, F_DONE | F_BUSY, 0);
        mem_ready = 1'b0;

        // Three memory wait cycles, run dropped in T2: 9 cycles then IDLE
        tick(); checkState("wait_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        tick(); checkState("wait_t1a", B_ZLO, 0, F_PC | F_MRD | F_BUSY, 0);
        tick(); checkState("wait_t1b", B_ZLO, 0, F_PC | F_MRD | F_BUSY, 0);
        tick(); checkState("wait_t1c", B_ZLO, 0, F_PC | F_MRD | F_BUSY, 0);
        tick(); mem_ready = 1'b1; #1;
        checkState("wait_t1d", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("wait_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        run = 1'b0;
        tick(); checkState("wait_t3", 32'h0000_0004, 0, F_Y | F_BUSY, 0);
        tick(); checkState("wait_t4", 32'h0000_0001, 0, F_Z | F_BUSY, 3);
        tick(); checkState("wait_t5", B_ZLO, 32'h0004, F_DONE | F_BUSY, 0);
        tick(); checkState("wait_idle", 0, 0, 0, 0);
        tick(); checkState("wait_idle2", 0, 0, 0, 0);

        // MUL rb=5 rc=6
        applyStimulus(32'h782B_0000, 1'b1, 1'b1);
        tick(); checkState("mul_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        run = 1'b0;
        tick(); checkState("mul_t1", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("mul_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        tick(); checkState("mul_t3", 32'h0000_0020, 0, F_Y | F_BUSY, 0);
        tick(); checkState("mul_t4", 32'h0000_0040, 0, F_Z | F_BUSY, 15);
        tick(); checkState("mul_t5", B_ZLO, 0, F_LO | F_BUSY, 0);
        tick(); checkState("mul_t6", B_ZHI, 0, F_HI | F_DONE | F_BUSY, 0);
        tick(); checkState("mul_idle", 0, 0, 0, 0);

        // Illegal opcode 31 with run held: next fetch begins right after
        applyStimulus(32'hF800_0000, 1'b1, 1'b1);
        tick(); checkState("ill_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        tick(); checkState("ill_t1", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("ill_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        tick(); checkState("ill_t3", 0, 0, F_ILL | F_BUSY, 0);
        tick(); checkState("ill_next_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        run = 1'b0;
        tick(); checkState("ill2_t1", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("ill2_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        tick(); checkState("ill2_t3", 0, 0, F_ILL | F_BUSY, 0);
        tick(); checkState("ill_idle", 0, 0, 0, 0);

        // DIV rb=3 rc=4, asynchronous reset pulse while in T4
        applyStimulus(32'h801A_0000, 1'b1, 1'b1);
        tick(); checkState("rst_t0", B_PC, 0, F_Z | F_MAR | F_INC | F_BUSY, 0);
        run = 1'b0;
        tick(); checkState("rst_t1", B_ZLO, 0, F_PC | F_MRD | F_MDR | F_BUSY, 0);
        tick(); checkState("rst_t2", B_MDR, 0, F_IR | F_BUSY, 0);
        tick(); checkState("rst_t3", 32'h0000_0008, 0, F_Y | F_BUSY, 0);
        tick(); checkState("rst_t4", 32'h0000_0010, 0, F_Z | F_BUSY, 16);
        #1 clr = 1'b0;
        #1 checkState("rst_async", 0, 0, 0, 0);
        clr = 1'b1;
        tick(); checkState("rst_idle", 0, 0, 0, 0);
        tick(); checkState("rst_idle2", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
